branch_flag_ctrl: RTL and testbench
===================================

Name: branch_flag_ctrl

Overview:
- Branch-resolution controller for the pipelined CPU.
- Owns the architectural NZCV flag register and the 64-bit zero detector instance.
- Resolves CBZ/CBNZ/B.cond/B for the instruction in decode, with flag forwarding from EX.
- Sequences operand-wait stalls and the one-cycle flush after a taken branch.

Parameters:
- WIDTH, 64: datapath width of ex_result and br_operand; the zero detector is only defined at 64.
- MAX_WAIT, 4: maximum stall cycles waiting for br_operand before wait_timeout asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_set_flags  in  1  EX-stage instruction writes flags this cycle.
- ex_result  in  WIDTH  EX-stage ALU result; its zero test gives Z.
- ex_nzcv_ncv  in  3  EX ALU {N,C,V}.
- br_valid  in  1  decode holds a branch to resolve.
- br_type  in  2  0=B, 1=CBZ, 2=CBNZ, 3=B.cond.
- br_cond  in  4  ARM condition code for B.cond.
- br_operand  in  WIDTH  forwarded register value for CBZ/CBNZ.
- br_operand_ready  in  1  br_operand is valid this cycle.
- stall  out  1  hold fetch/decode.
- flush  out  1  squash the instruction in decode.
- resolve_valid  out  1  registered pulse: a branch resolved last cycle.
- taken  out  1  registered with resolve_valid: branch taken.
- flags_q  out  4  architectural {N,Z,C,V}.
- wait_timeout  out  1  sticky: operand wait exceeded MAX_WAIT.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; flags_q=0; wait counter=0.
  - stall, flush, resolve_valid, taken, wait_timeout all 0.
  - Reset mid-WAIT or mid-FLUSH aborts the branch with no resolve pulse.
- Flag register:
  - On each edge with ex_set_flags=1, flags_q <= {N, zero(ex_result), C, V}.
  - This update happens in every state, including FLUSH, because the EX instruction is older than the branch.
- Effective flags for B.cond: use the EX values when ex_set_flags=1 in the same cycle (forwarding); otherwise use flags_q.
- Conditions:
  - EQ: Z. NE: !Z. HS: C. LO: !C. MI: N. PL: !N. VS: V. VC: !V.
  - HI: C&!Z. LS: !C|Z. GE: N==V. LT: N!=V.
  - GT: !Z&(N==V). LE: Z|(N!=V). 1110 and 1111: always taken.
- Taken:
  - B: always taken.
  - CBZ: zero(br_operand).
  - CBNZ: !zero(br_operand).
  - B.cond: condition evaluated on the effective flags.
- FSM states: IDLE, WAIT, FLUSH.
  - IDLE, br_valid=1 and the branch needs no operand (B, B.cond) or br_operand_ready=1: resolve this cycle.
    - Next edge: resolve_valid=1 and taken=result.
    - Next state is FLUSH if taken, else IDLE.
  - IDLE, CBZ/CBNZ with br_operand_ready=0: stall=1 combinationally; go to WAIT; counter<=1.
  - WAIT: stall=1.
    - When br_operand_ready=1: stall drops to 0 that cycle and the branch resolves as in IDLE.
    - Otherwise counter increments, saturating.
    - When counter reaches MAX_WAIT, wait_timeout<=1 (sticky until reset) and the FSM stays in WAIT.
    - br_valid dropping in WAIT returns to IDLE with no resolve.
  - FLUSH: flush=1 for exactly one cycle, stall=0, br_valid ignored; then IDLE.
- Output timing:
  - resolve_valid and taken are registered and pulse for one cycle.
  - taken=0 whenever resolve_valid=0.
- Back-to-back branches:
  - A non-taken resolve in IDLE accepts a new br_valid on the next cycle.
  - A taken resolve always costs the FLUSH cycle.

Decomposition:
- Shared package cpu_pkg:
  - br_type_e enum: BR_B, BR_CBZ, BR_CBNZ, BR_COND.
  - cond_e constants: EQ through AL.
  - bfc_state_e enum: IDLE, WAIT, FLUSH.
  - flag bit index constants.
- Sub-module cond_eval: combinational (cond, nzcv) -> pass.
- Instantiate zeroCase twice: once on ex_result, once on br_operand.

Test Plan:
- Reset released, then B (type 0) with br_valid for 1 cycle -> next cycle resolve_valid=1, taken=1; following cycle flush=1, stall=0; then idle.
- CBZ, br_operand=0, ready=1 -> taken=1, flush pulses once. CBNZ, br_operand=64'h0000000010000000 -> taken=1. CBZ with the same operand -> taken=0, no flush.
- ex_set_flags=1, ex_result=0, NCV=000, with B.cond EQ in the same cycle -> taken=1 via forwarding; flags_q=4'b0100 after the edge. B.cond NE next cycle -> taken=0.
- CBZ with ready low for 2 cycles -> stall=1 for those 2 cycles; ready=1 with operand=0 on cycle 3 -> stall=0, resolve_valid next edge with taken=1.
- CBZ with ready held low for MAX_WAIT=4 cycles -> wait_timeout=1 and stays 1; reset low mid-WAIT -> state IDLE, stall=0, flags_q=0, wait_timeout=0, no resolve pulse.
- Flag set (ex_result=64'h1, NCV=100) during a FLUSH cycle -> flags_q=4'b1000 after the edge; br_valid asserted during FLUSH is ignored (no resolve_valid).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch types, ARM condition codes, branch/flag
// controller states and NZCV bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_B    = 2'd0,
        BR_CBZ  = 2'd1,
        BR_CBNZ = 2'd2,
        BR_COND = 2'd3
    } br_type_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } bfc_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: purely combinational (cond, nzcv) -> pass.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_HS: pass = c;
            COND_LO: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end
endmodule

// File: rtl/zeroCase.sv
// 64-bit zero detector.
module zeroCase (
    input  logic [63:0] value,
    output logic        zero
);
    assign zero = ~|value;
endmodule

// File: rtl/branch_flag_ctrl.sv
// Branch-resolution controller: owns NZCV, resolves the decode-stage branch
// with EX flag forwarding, and sequences operand-wait stalls and flushes.
//
// state | meaning
// IDLE  | no branch pending; resolve immediately when possible
// WAIT  | CBZ/CBNZ stalled until br_operand_ready
// FLUSH | one-cycle squash of decode after a taken branch
module branch_flag_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_set_flags,
    input  logic [WIDTH-1:0] ex_result,
    input  logic [2:0]       ex_nzcv_ncv,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [3:0]       br_cond,
    input  logic [WIDTH-1:0] br_operand,
    input  logic             br_operand_ready,
    output logic             stall,
    output logic             flush,
    output logic             resolve_valid,
    output logic             taken,
    output logic [3:0]       flags_q,
    output logic             wait_timeout
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    bfc_state_e       state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             ex_zero, op_zero, cond_pass;
    logic [3:0]       ex_flags, eff_flags;
    br_type_e         br_kind;
    logic             needs_op, take_result, resolve, timeout_set;

    zeroCase u_zero_ex (.value(ex_result),  .zero(ex_zero));
    zeroCase u_zero_op (.value(br_operand), .zero(op_zero));

    assign ex_flags  = {ex_nzcv_ncv[2], ex_zero, ex_nzcv_ncv[1], ex_nzcv_ncv[0]};
    // Forward EX flags so a B.cond right behind a flag-setter sees them.
    assign eff_flags = ex_set_flags ? ex_flags : flags_q;

    cond_eval u_cond (.cond(br_cond), .nzcv(eff_flags), .pass(cond_pass));

    assign br_kind  = br_type_e'(br_type);
    assign needs_op = (br_kind == BR_CBZ) || (br_kind == BR_CBNZ);

    always_comb begin
        take_result = 1'b1;
        case (br_kind)
            BR_B:    take_result = 1'b1;
            BR_CBZ:  take_result = op_zero;
            BR_CBNZ: take_result = !op_zero;
            BR_COND: take_result = cond_pass;
            default: take_result = 1'b1;
        endcase
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        stall         = 1'b0;
        flush         = 1'b0;
        resolve       = 1'b0;
        timeout_set   = 1'b0;
        case (state)
            IDLE: begin
                if (br_valid) begin
                    if (needs_op && !br_operand_ready) begin
                        stall         = 1'b1;
                        state_next    = WAIT;
                        wait_cnt_next = CNT_ONE;
                        timeout_set   = (CNT_ONE >= CNT_MAX);
                    end else begin
                        resolve    = 1'b1;
                        state_next = take_result ? FLUSH : IDLE;
                    end
                end
            end
            WAIT: begin
                if (!br_valid) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (br_operand_ready || !needs_op) begin
                    resolve       = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = take_result ? FLUSH : IDLE;
                end else begin
                    stall = 1'b1;
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt_next = wait_cnt + CNT_ONE;
                    end
                    timeout_set = (wait_cnt_next == CNT_MAX);
                end
            end
            FLUSH: begin
                flush      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            flags_q       <= '0;
            resolve_valid <= 1'b0;
            taken         <= 1'b0;
            wait_timeout  <= 1'b0;
        end else begin
            state         <= state_next;
            wait_cnt      <= wait_cnt_next;
            resolve_valid <= resolve;
            taken         <= resolve && take_result;
            wait_timeout  <= wait_timeout || timeout_set;
            // The EX instruction is older than any branch, so it always commits.
            if (ex_set_flags) begin
                flags_q <= ex_flags;
            end
        end
    end

endmodule

// File: tb/tb_branch_flag_ctrl.sv
// Randomized and directed bench for branch_flag_ctrl against a behavioural model.
module tb_branch_flag_ctrl;
    localparam int WIDTH    = 64;
    localparam int MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_set_flags;
    logic [WIDTH-1:0] ex_result;
    logic [2:0]       ex_nzcv_ncv;
    logic             br_valid;
    logic [1:0]       br_type;
    logic [3:0]       br_cond;
    logic [WIDTH-1:0] br_operand;
    logic             br_operand_ready;
    logic             stall, flush, resolve_valid, taken, wait_timeout;
    logic [3:0]       flags_q;

    branch_flag_ctrl #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .ex_set_flags(ex_set_flags), .ex_result(ex_result), .ex_nzcv_ncv(ex_nzcv_ncv),
        .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond),
        .br_operand(br_operand), .br_operand_ready(br_operand_ready),
        .stall(stall), .flush(flush), .resolve_valid(resolve_valid), .taken(taken),
        .flags_q(flags_q), .wait_timeout(wait_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state: flags, pending flush, operand-wait length, sticky timeout.
    logic [3:0] m_flags;
    bit         m_flush_due;
    int         m_wait;
    bit         m_timeout;

    // Codes pair up: odd code is the negation of the even one; 111x always passes.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic idle_inputs();
        ex_set_flags = 0; ex_result = 64'h1; ex_nzcv_ncv = 3'b000;
        br_valid = 0; br_type = 2'd0; br_cond = 4'h0;
        br_operand = 64'h1; br_operand_ready = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, registered ones after the edge.
    task automatic step();
        bit exp_stall, exp_flush, res, tk, to;
        logic [3:0] exf, eff;
        int nw;
        @(negedge clk);
        exf = {ex_nzcv_ncv[2], (ex_result == 64'd0), ex_nzcv_ncv[1:0]};
        eff = ex_set_flags ? exf : m_flags;
        exp_stall = 0; exp_flush = 0; res = 0; tk = 0; nw = 0; to = m_timeout;
        if (m_flush_due) begin
            exp_flush = 1;
        end else if (br_valid) begin
            if ((br_type == 2'd1 || br_type == 2'd2) && !br_operand_ready) begin
                exp_stall = 1;
                nw = (m_wait == 0) ? 1 : ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT);
                if (nw >= MAX_WAIT) to = 1;
            end else begin
                res = 1;
                case (br_type)
                    2'd0: tk = 1;
                    2'd1: tk = (br_operand == 64'd0);
                    2'd2: tk = (br_operand != 64'd0);
                    default: tk = cond_ok(br_cond, eff);
                endcase
            end
        end
        chk("stall", 64'(stall), 64'(exp_stall));
        chk("flush", 64'(flush), 64'(exp_flush));
        @(posedge clk);
        #1;
        if (ex_set_flags) m_flags = exf;
        m_flush_due = res && tk;
        m_wait      = nw;
        m_timeout   = to;
        chk("resolve_valid", 64'(resolve_valid), 64'(res));
        chk("taken", 64'(taken), 64'(tk));
        chk("flags_q", 64'(flags_q), 64'(m_flags));
        chk("wait_timeout", 64'(wait_timeout), 64'(m_timeout));
    endtask

    // Asynchronous reset, checked before any clock edge; returns at posedge+1.
    task automatic do_reset();
        #2;
        idle_inputs();
        reset = 0;
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_resolve_valid", 64'(resolve_valid), 64'd0);
        chk("rst_taken", 64'(taken), 64'd0);
        chk("rst_flags_q", 64'(flags_q), 64'd0);
        chk("rst_wait_timeout", 64'(wait_timeout), 64'd0);
        m_flags = 4'd0; m_flush_due = 0; m_wait = 0; m_timeout = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic branch(input logic [1:0] t, input logic [3:0] c,
                          input logic [63:0] op, input logic rdy);
        br_valid = 1; br_type = t; br_cond = c; br_operand = op; br_operand_ready = rdy;
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        m_flags = 4'd0; m_flush_due = 0; m_wait = 0; m_timeout = 0;
        do_reset();
        step();

        // Unconditional branch, then its flush cycle.
        branch(2'd0, 4'h0, 64'h1, 1'b0);
        step();
        chk("b_rv", 64'(resolve_valid), 64'd1);
        chk("b_taken", 64'(taken), 64'd1);
        idle_inputs();
        chk("b_flush", 64'(flush), 64'd1);
        step();
        step();

        // CBZ zero, CBNZ non-zero, CBZ non-zero.
        branch(2'd1, 4'h0, 64'h0, 1'b1);
        step();
        chk("cbz0_taken", 64'(taken), 64'd1);
        idle_inputs();
        step();
        branch(2'd2, 4'h0, 64'h0000000010000000, 1'b1);
        step();
        chk("cbnz_taken", 64'(taken), 64'd1);
        idle_inputs();
        step();
        branch(2'd1, 4'h0, 64'h0000000010000000, 1'b1);
        step();
        chk("cbz_nt_taken", 64'(taken), 64'd0);
        idle_inputs();
        chk("cbz_nt_flush", 64'(flush), 64'd0);
        step();

        // B.cond EQ using forwarded EX flags, then NE from flags_q.
        branch(2'd3, 4'h0, 64'h1, 1'b0);
        ex_set_flags = 1; ex_result = 64'h0; ex_nzcv_ncv = 3'b000;
        step();
        chk("fwd_eq_taken", 64'(taken), 64'd1);
        chk("fwd_flags", 64'(flags_q), 64'b0100);
        idle_inputs();
        step();
        branch(2'd3, 4'h1, 64'h1, 1'b0);
        step();
        chk("ne_taken", 64'(taken), 64'd0);
        chk("ne_rv", 64'(resolve_valid), 64'd1);

        // CBZ waiting two cycles for its operand.
        branch(2'd1, 4'h0, 64'h5, 1'b0);
        step();
        step();
        br_operand = 64'h0; br_operand_ready = 1;
        #1;
        chk("wait_stall_drop", 64'(stall), 64'd0);
        step();
        chk("wait_taken", 64'(taken), 64'd1);
        idle_inputs();
        step();

        // Operand never arrives: timeout after MAX_WAIT stall cycles, then reset mid-wait.
        branch(2'd1, 4'h0, 64'h5, 1'b0);
        for (int i = 0; i < MAX_WAIT - 1; i++) step();
        chk("timeout_early", 64'(wait_timeout), 64'd0);
        step();
        chk("timeout_set", 64'(wait_timeout), 64'd1);
        step();
        step();
        chk("timeout_sticky", 64'(wait_timeout), 64'd1);
        do_reset();
        step();

        // Flags update during FLUSH; a branch offered during FLUSH is ignored.
        branch(2'd0, 4'h0, 64'h1, 1'b0);
        step();
        ex_set_flags = 1; ex_result = 64'h1; ex_nzcv_ncv = 3'b100;
        br_valid = 1; br_type = 2'd0;
        step();
        chk("flush_flags", 64'(flags_q), 64'b1000);
        chk("flush_ignore_rv", 64'(resolve_valid), 64'd0);
        idle_inputs();
        step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            br_valid         = ($urandom_range(0, 9) < 7);
            br_type          = 2'($urandom_range(0, 3));
            br_cond          = 4'($urandom_range(0, 15));
            br_operand       = ($urandom_range(0, 9) < 4) ? 64'd0 : {32'($urandom), 32'($urandom)};
            br_operand_ready = ($urandom_range(0, 9) < 6);
            ex_set_flags     = ($urandom_range(0, 1) == 1);
            ex_result        = ($urandom_range(0, 9) < 3) ? 64'd0 : {32'($urandom), 32'($urandom)};
            ex_nzcv_ncv      = 3'($urandom_range(0, 7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
